// File: rtl/bcd_mod_counter.sv
// Packed-BCD up/down modulo counter with synchronous load, wrap pulse and
// combinational cascade flag for chaining stages (e.g. seconds -> minutes -> hours).
module bcd_mod_counter #(
    parameter int unsigned DIGITS    = 2,
    parameter int unsigned MODULUS   = 24,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  cascade_out,
    output logic                  load_err
);

    localparam int unsigned W = 4 * DIGITS;

    function automatic logic [W-1:0] to_bcd(input int unsigned v);
        logic [W-1:0] r;
        int unsigned  t;
        r = '0;
        t = v;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    localparam logic [W-1:0] MAX_BCD = to_bcd(MODULUS - 1);
    localparam logic [W-1:0] RST_BCD = to_bcd(RESET_VAL);

    logic [W-1:0] inc_val;
    logic [W-1:0] dec_val;
    logic         carry;
    logic         borrow;
    logic         digits_ok;
    logic         load_ok;
    logic         at_max;
    logic         at_zero;

    assign at_max  = (count == MAX_BCD);
    assign at_zero = (count == '0);

    // Ripple +1 / -1 across digits; only used when not at a terminal value,
    // so the top digit never carries or borrows out.
    always_comb begin
        inc_val = count;
        dec_val = count;
        carry   = 1'b1;
        borrow  = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (count[4*i +: 4] == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = count[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (count[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = count[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    // With every digit valid, packed-BCD ordering equals numeric ordering.
    always_comb begin
        digits_ok = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9) begin
                digits_ok = 1'b0;
            end
        end
        load_ok = digits_ok && (load_val <= MAX_BCD);
    end

    assign cascade_out = en && (up ? at_max : at_zero);

    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= RST_BCD;
            tc       <= 1'b0;
            load_err <= 1'b0;
        end else begin
            tc       <= 1'b0;
            load_err <= 1'b0;
            if (load) begin
                if (load_ok) begin
                    count <= load_val;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (en) begin
                if (up) begin
                    if (at_max) begin
                        count <= '0;
                        tc    <= 1'b1;
                    end else begin
                        count <= inc_val;
                    end
                end else begin
                    if (at_zero) begin
                        count <= MAX_BCD;
                        tc    <= 1'b1;
                    end else begin
                        count <= dec_val;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Scoreboard bench: a mod-24 counter plus a 60->24 cascaded pair, checked
// against an integer reference model under directed and random stimulus.
module tb_bcd_mod_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [7:0] load_val = '0;
    logic [7:0] count;
    logic       tc;
    logic       cascade_out;
    logic       load_err;

    logic       c_en = 1'b0;
    logic       c_load = 1'b0;
    logic [7:0] c_lv_lo = '0;
    logic [7:0] c_lv_hi = '0;
    logic [7:0] c_lo;
    logic [7:0] c_hi;
    logic       c_tc_lo;
    logic       c_tc_hi;
    logic       c_casc_lo;
    logic       c_casc_hi;
    logic       c_lerr_lo;
    logic       c_lerr_hi;

    always #5 clk = ~clk;

    bcd_mod_counter #(.DIGITS(2), .MODULUS(24), .RESET_VAL(0)) dut (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(count), .tc(tc),
        .cascade_out(cascade_out), .load_err(load_err)
    );

    bcd_mod_counter #(.DIGITS(2), .MODULUS(60), .RESET_VAL(0)) u_lo (
        .clk(clk), .reset(reset), .en(c_en), .up(1'b1), .load(c_load),
        .load_val(c_lv_lo), .count(c_lo), .tc(c_tc_lo),
        .cascade_out(c_casc_lo), .load_err(c_lerr_lo)
    );

    bcd_mod_counter #(.DIGITS(2), .MODULUS(24), .RESET_VAL(0)) u_hi (
        .clk(clk), .reset(reset), .en(c_casc_lo), .up(1'b1), .load(c_load),
        .load_val(c_lv_hi), .count(c_hi), .tc(c_tc_hi),
        .cascade_out(c_casc_hi), .load_err(c_lerr_hi)
    );

    typedef struct {
        logic [7:0] cnt;
        logic       tc;
        logic       le;
        logic [7:0] lo;
        logic [7:0] hi;
        logic       tlo;
        logic       thi;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    int m_cnt = 0;
    int m_lo = 0;
    int m_hi = 0;

    function automatic logic [7:0] bcd2(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, req, $time);
        end
    endtask

    // One cycle: drive inputs after negedge, check the combinational flag,
    // advance the model and queue the post-edge expectation.
    task automatic step(input logic r, input logic e, input logic u, input logic l,
                        input logic [7:0] lv, input logic ce, input logic cl,
                        input logic [7:0] clo, input logic [7:0] chi);
        exp_t x;
        int   d0;
        int   d1;
        @(negedge clk);
        reset = r; en = e; up = u; load = l; load_val = lv;
        c_en = ce; c_load = cl; c_lv_lo = clo; c_lv_hi = chi;
        #1;
        if (!r) begin
            check1("cascade_out", cascade_out, e && (u ? (m_cnt == 23) : (m_cnt == 0)));
            check1("cascade_lo", c_casc_lo, ce && (m_lo == 59));
        end
        x.tc = 1'b0; x.le = 1'b0; x.tlo = 1'b0; x.thi = 1'b0;
        d0 = int'(lv[3:0]);
        d1 = int'(lv[7:4]);
        if (r) begin
            m_cnt = 0;
        end else if (l) begin
            if (d0 <= 9 && d1 <= 9 && (d1 * 10 + d0) < 24) m_cnt = d1 * 10 + d0;
            else x.le = 1'b1;
        end else if (e) begin
            if (u) begin
                x.tc  = (m_cnt == 23);
                m_cnt = (m_cnt + 1) % 24;
            end else begin
                x.tc  = (m_cnt == 0);
                m_cnt = (m_cnt + 23) % 24;
            end
        end
        if (r) begin
            m_lo = 0; m_hi = 0;
        end else if (cl) begin
            m_lo = int'(clo[7:4]) * 10 + int'(clo[3:0]);
            m_hi = int'(chi[7:4]) * 10 + int'(chi[3:0]);
        end else if (ce) begin
            if (m_lo == 59) begin
                x.tlo = 1'b1;
                x.thi = (m_hi == 23);
                m_hi  = (m_hi + 1) % 24;
            end
            m_lo = (m_lo + 1) % 60;
        end
        x.cnt = bcd2(m_cnt);
        x.lo  = bcd2(m_lo);
        x.hi  = bcd2(m_hi);
        exp_q.push_back(x);
    endtask

    task automatic main_step(input logic r, input logic e, input logic u, input logic l,
                             input logic [7:0] lv);
        step(r, e, u, l, lv, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    // Monitor: every cycle the DUT presents count/tc/load_err after the edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check8("count", count, x.cnt);
                check1("tc", tc, x.tc);
                check1("load_err", load_err, x.le);
                check1("count_valid_bcd", (count[3:0] <= 4'd9) && (count[7:4] <= 4'd9)
                       && (count < 8'h24), 1'b1);
                check8("chain_lo", c_lo, x.lo);
                check8("chain_hi", c_hi, x.hi);
                check1("chain_tc_lo", c_tc_lo, x.tlo);
                check1("chain_tc_hi", c_tc_hi, x.thi);
            end
        end
    end

    initial begin
        logic [7:0] lv;
        int         waited;

        main_step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 10; i++) main_step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        main_step(1'b0, 1'b0, 1'b1, 1'b1, 8'h23);
        main_step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        main_step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

        main_step(1'b0, 1'b0, 1'b0, 1'b1, 8'h10);
        main_step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        main_step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        main_step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        main_step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);

        main_step(1'b0, 1'b1, 1'b1, 1'b1, 8'h1A);
        main_step(1'b0, 1'b0, 1'b1, 1'b1, 8'h24);
        main_step(1'b0, 1'b0, 1'b1, 1'b1, 8'h17);
        main_step(1'b0, 1'b0, 1'b1, 1'b1, 8'h23);
        main_step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        main_step(1'b0, 1'b1, 1'b1, 1'b1, 8'h05);
        main_step(1'b1, 1'b1, 1'b1, 1'b1, 8'h1F);
        main_step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h58, 8'h23);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h59, 8'h09);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00);

        for (int i = 0; i < 12000; i++) begin
            if ($urandom_range(0, 1) == 0) lv = 8'($urandom_range(0, 255));
            else lv = bcd2(int'($urandom_range(0, 23)));
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) == 0,
                 lv,
                 $urandom_range(0, 7) != 0,
                 $urandom_range(0, 499) == 0,
                 bcd2(int'($urandom_range(0, 59))),
                 bcd2(int'($urandom_range(0, 23))));
        end

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_mod_counter.md
BCD_MOD_COUNTER -- requirements
Module: bcd_mod_counter

Interface
REQ-001 The block SHALL have parameter DIGITS, default 2, number of BCD digits (legal 1..4).
REQ-002 The block SHALL have parameter MODULUS, default 24, count range 0..MODULUS-1 (legal 2..10^DIGITS).
REQ-003 The block SHALL have parameter RESET_VAL, default 0, binary count value after reset (legal 0..MODULUS-1).
REQ-004 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-005 The block SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-006 The block SHALL have port en, input, 1, count-step enable for the current cycle.
REQ-007 The block SHALL have port up, input, 1, direction: 1 = increment, 0 = decrement.
REQ-008 The block SHALL have port load, input, 1, synchronous load request.
REQ-009 The block SHALL have port load_val, input, 4*DIGITS, packed BCD load value, digit 0 in [3:0].
REQ-010 The block SHALL have port count, output, 4*DIGITS, registered packed BCD count value.
REQ-011 The block SHALL have port tc, output, 1, registered one-cycle wrap pulse.
REQ-012 The block SHALL have port cascade_out, output, 1, combinational flag: en high and count at its terminal value for the current direction.
REQ-013 The block SHALL have port load_err, output, 1, registered one-cycle pulse flagging a rejected load.

Function
REQ-014 Per-cycle priority SHALL be reset > load > en > hold.
REQ-015 When up=1 and en=1, count SHALL step +1 in BCD: a digit at 9 SHALL become 0 and carry +1 into the next digit.
REQ-016 When up=1, en=1 and count = MODULUS-1, count SHALL wrap to 0 and tc SHALL be 1 in the following cycle.
REQ-017 When up=0 and en=1, count SHALL step -1 in BCD: a digit at 0 SHALL become 9 and borrow from the next digit.
REQ-018 When up=0, en=1 and count = 0, count SHALL wrap to MODULUS-1 in BCD and tc SHALL be 1 in the following cycle.
REQ-019 tc SHALL be 1 for exactly the one cycle in which count first shows the wrapped value, and 0 otherwise.
REQ-020 cascade_out SHALL equal en AND ((up AND count = MODULUS-1) OR (NOT up AND count = 0)), with no register stage, so it can drive the en of a following stage in the same cycle.
REQ-021 A load SHALL be accepted only if every digit of load_val is ≤ 9 and the value is < MODULUS; an accepted load SHALL set count = load_val on the next edge.
REQ-022 A rejected load SHALL leave count unchanged, SHALL suppress any en step in that cycle, and SHALL set load_err = 1 for the next cycle.
REQ-023 load SHALL never assert tc, even when the loaded value equals a terminal value.
REQ-024 With en=0 and load=0, count SHALL hold and tc and load_err SHALL be 0.
REQ-025 Changing up between cycles SHALL take effect on the next step with no extra latency.
REQ-026 count SHALL never hold a non-BCD digit or a value ≥ MODULUS.

Reset
REQ-027 While reset is 1 at a clock edge, count SHALL become RESET_VAL in BCD, and tc and load_err SHALL become 0, regardless of en and load.
REQ-028 A reset asserted mid-count or during a load SHALL discard the pending step or load with no residual tc or load_err pulse.

Verification
REQ-029 With DIGITS=2, MODULUS=24, RESET_VAL=0, assert reset and then en=1, up=1: count 0x00 after reset; 0x09 -> 0x10; 0x23 -> 0x00 with tc=1 for one cycle.
REQ-030 With up=0, en=1: 0x10 -> 0x09; 0x00 -> 0x23 with tc=1; cascade_out=1 only while count=0x00 and en=1.
REQ-031 Load 0x1A -> count held and load_err=1; load 0x24 -> rejected with load_err=1; load 0x17 -> count=0x17, load_err=0, tc=0.
REQ-032 Assert load=1 (0x05) and en=1 in the same cycle -> count=0x05; assert reset=1 with load=1 -> count=RESET_VAL, with no tc or load_err.
REQ-033 Chain a MODULUS=60 instance (en=1, up=1) into a MODULUS=24 instance through cascade_out -> en: the high stage steps only when the low stage goes 0x59 -> 0x00; 23:59 -> 00:00 with tc=1 on both stages in the same cycle.
REQ-034 Run a random en/up/load sweep of at least 10k cycles against a binary reference model mod MODULUS: count, tc and load_err match every cycle, and no invalid BCD value appears.
